// File: rtl/tqv_spi_pkg.sv
// Shared types and constants for the TinyQV SPI register bridge.
package tqv_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } spi_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_pin_sync_edge.sv
// N-stage input synchroniser with single-cycle rise/fall pulses on the synced level.
module spi_pin_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/tqv_spi_reg_bridge.sv
// SPI mode-0 slave to register-port bridge with burst auto-increment and read prefetch.
module tqv_spi_reg_bridge
  import tqv_spi_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic              busy
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int AS_W  = ADDR_W - 1;

  logic cs_sync, cs_fall, unused_cs_rise;
  logic unused_sck_sync, sck_rise, sck_fall;
  logic mosi_sync, unused_mosi_rise, unused_mosi_fall;

  spi_pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .pin(spi_cs_n),
    .sync(cs_sync), .rise(unused_cs_rise), .fall(cs_fall)
  );

  spi_pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .pin(spi_clk),
    .sync(unused_sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .pin(spi_mosi),
    .sync(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic              is_write;
  logic              rd_arm;
  logic [AS_W-1:0]   addr_sr;
  logic [DATA_W-2:0] data_sr;
  logic [DATA_W-2:0] miso_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      is_write   <= CMD_READ;
      rd_arm     <= 1'b0;
      addr_sr    <= '0;
      data_sr    <= '0;
      miso_sr    <= '0;
      reg_addr   <= '0;
      reg_data_o <= '0;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      spi_miso   <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      // Every write strobe and every read prefetch advances the address, wrapping naturally.
      if (reg_wr || reg_rd) reg_addr <= reg_addr + 1'b1;
      if (reg_rd) begin
        miso_sr  <= reg_data_i[DATA_W-2:0];
        spi_miso <= reg_data_i[DATA_W-1];
      end

      unique case (state)
        IDLE: begin
          if (cs_fall) state <= CMD;
        end
        CMD: begin
          if (sck_rise) begin
            is_write <= mosi_sync;
            bit_cnt  <= CNT_W'(ADDR_W);
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_sr <= AS_W'({addr_sr, mosi_sync});
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == CNT_W'(1)) begin
              reg_addr <= {addr_sr, mosi_sync};
              bit_cnt  <= CNT_W'(DATA_W);
              rd_arm   <= (is_write == CMD_READ);
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            data_sr <= {data_sr[DATA_W-3:0], mosi_sync};
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == CNT_W'(1)) begin
              bit_cnt <= CNT_W'(DATA_W);
              if (is_write == CMD_WRITE) begin
                reg_data_o <= {data_sr, mosi_sync};
                reg_wr     <= 1'b1;
              end else begin
                rd_arm <= 1'b1;
              end
            end
          end
          // The first falling edge after a field boundary fetches the next word; others shift MISO.
          if (sck_fall && is_write == CMD_READ) begin
            if (rd_arm) begin
              reg_rd <= 1'b1;
              rd_arm <= 1'b0;
            end else begin
              spi_miso <= miso_sr[DATA_W-2];
              miso_sr  <= {miso_sr[DATA_W-3:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cs_sync) begin
        state    <= IDLE;
        rd_arm   <= 1'b0;
        spi_miso <= 1'b0;
      end
    end
  end

  assign busy = ~cs_sync;

endmodule

// File: tb/tb_tqv_spi_reg_bridge.sv
// Bench for tqv_spi_reg_bridge: 32-bit and 8-bit data builds share the SPI pins.
module tb_tqv_spi_reg_bridge;
  import tqv_spi_pkg::*;

  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;

  always #5 clk = ~clk;

  logic        miso_a, wr_a, rds_a, busy_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        miso_b, wr_b, rds_b, busy_b;
  logic [5:0]  addr_b;
  logic [7:0]  wdata_b, rdata_b;

  assign rdata_a = {26'b0, addr_a} ^ 32'hA5A5A5A5;
  assign rdata_b = {2'b0, addr_b} ^ 8'h5A;

  tqv_spi_reg_bridge #(.ADDR_W(6), .DATA_W(32), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_clk(sck), .spi_mosi(mosi),
    .spi_miso(miso_a), .reg_addr(addr_a), .reg_data_o(wdata_a), .reg_wr(wr_a),
    .reg_rd(rds_a), .reg_data_i(rdata_a), .busy(busy_a)
  );

  tqv_spi_reg_bridge #(.ADDR_W(6), .DATA_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(cs_n), .spi_clk(sck), .spi_mosi(mosi),
    .spi_miso(miso_b), .reg_addr(addr_b), .reg_data_o(wdata_b), .reg_wr(wr_b),
    .reg_rd(rds_b), .reg_data_i(rdata_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Strobe monitor
  logic [37:0] wq_a[$];
  logic [13:0] wq_b[$];
  int rdn_a = 0, rdn_b = 0, dbl = 0;
  logic pw_a = 1'b0, pw_b = 1'b0;

  always @(negedge clk) begin
    if (wr_a) wq_a.push_back({addr_a, wdata_a});
    if (wr_b) wq_b.push_back({addr_b, wdata_b});
    if (rds_a) rdn_a++;
    if (rds_b) rdn_b++;
    if ((wr_a && pw_a) || (wr_b && pw_b)) dbl++;
    pw_a = wr_a;
    pw_b = wr_b;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    wq_a.delete();
    wq_b.delete();
    rdn_a = 0;
    rdn_b = 0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(HALF);
    m = miso_a;
    sck = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
  endtask

  logic [3:0][31:0] tx_w, rx_w;

  task automatic send_hdr(input bit wr, input logic [5:0] a);
    logic m;
    cs_n = 1'b0;
    wait_clk(HALF);
    spi_bit(wr, m);
    for (int i = 5; i >= 0; i--) spi_bit(a[i], m);
  endtask

  task automatic run_frame(input bit wr, input logic [5:0] a, input int n, input int wb);
    logic m;
    logic [31:0] acc;
    send_hdr(wr, a);
    rx_w = '0;
    for (int k = 0; k < n; k++) begin
      acc = '0;
      for (int i = wb - 1; i >= 0; i--) begin
        spi_bit(tx_w[k][i], m);
        acc = {acc[30:0], m};
      end
      rx_w[k] = acc;
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  typedef struct packed {
    bit               wr;
    logic [5:0]       addr;
    int               n;
    logic [3:0][31:0] w;
    logic [3:0][5:0]  exp_a;
    logic [3:0][31:0] exp_d;
    int               exp_rd;
    logic [5:0]       exp_end;
  } vec_t;

  // Reference: consecutive addresses mod 64; writes echo data, reads return addr ^ 0xA5A5A5A5.
  function automatic vec_t mk(input bit wr, input logic [5:0] a, input int n,
                              input logic [3:0][31:0] w);
    vec_t v;
    v = '0;
    v.wr = wr;
    v.addr = a;
    v.n = n;
    v.w = w;
    for (int i = 0; i < n; i++) begin
      v.exp_a[i] = a + 6'(i);
      v.exp_d[i] = wr ? w[i] : ({26'b0, v.exp_a[i]} ^ 32'hA5A5A5A5);
    end
    v.exp_rd = wr ? 0 : n + 1;
    v.exp_end = a + 6'(wr ? n : n + 1);
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    logic [37:0] e;
    clear_mon();
    tx_w = v.w;
    run_frame(v.wr, v.addr, v.n, 32);
    check({tag, "_wr_count"}, 32'(wq_a.size()), v.wr ? 32'(v.n) : 32'd0);
    check({tag, "_rd_count"}, 32'(rdn_a), 32'(v.exp_rd));
    for (int i = 0; i < v.n; i++) begin
      if (v.wr) begin
        if (i < wq_a.size()) begin
          e = wq_a[i];
          check($sformatf("%s_wr_addr%0d", tag, i), 32'(e[37:32]), 32'(v.exp_a[i]));
          check($sformatf("%s_wr_data%0d", tag, i), e[31:0], v.exp_d[i]);
        end
        check($sformatf("%s_miso_quiet%0d", tag, i), rx_w[i], 32'd0);
      end else begin
        check($sformatf("%s_miso_word%0d", tag, i), rx_w[i], v.exp_d[i]);
      end
    end
    check({tag, "_end_addr"}, 32'(addr_a), 32'(v.exp_end));
    check({tag, "_idle_miso"}, 32'(miso_a), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_a), 32'd0);
  endtask

  vec_t vt[10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][31:0] w;
    logic m;
    logic [31:0] word;
    logic [37:0] e;
    logic [13:0] e8;

    w = '0; w[0] = 32'hDEADBEEF;
    vt[0] = mk(1'b1, 6'h05, 1, w);
    w = '0; w[0] = 32'h11111111; w[1] = 32'h22222222;
    vt[1] = mk(1'b1, 6'h3F, 2, w);
    w = '0;
    vt[2] = mk(1'b0, 6'h0A, 1, w);
    for (int i = 3; i < 10; i++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      vt[i] = mk(1'($urandom_range(0, 1)), 6'($urandom), int'($urandom_range(1, 3)), w);
    end

    // Reset state
    wait_clk(3);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_wdata", wdata_a, 32'd0);
    check("rst_wr", 32'(wr_a), 32'd0);
    check("rst_rd", 32'(rds_a), 32'd0);
    check("rst_miso", 32'(miso_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < 10; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // CS rises mid-word: no write, back to idle quickly, address held
    clear_mon();
    word = $urandom;
    send_hdr(1'b1, 6'h02);
    for (int i = 31; i >= 15; i--) spi_bit(word[i], m);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(SYNC + 2);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_state", 32'(dut.state), 32'(IDLE));
    wait_clk(2 * HALF);
    check("abort_wr_count", 32'(wq_a.size()), 32'd0);
    check("abort_addr", 32'(addr_a), 32'h02);

    // CS rise coincident with the final bit's rising edge still completes the word
    clear_mon();
    word = $urandom;
    send_hdr(1'b1, 6'h07);
    for (int i = 31; i >= 1; i--) spi_bit(word[i], m);
    mosi = word[0];
    wait_clk(HALF);
    sck = 1'b1;
    cs_n = 1'b1;
    wait_clk(HALF);
    sck = 1'b0;
    wait_clk(2 * HALF);
    check("cs_edge_wr_count", 32'(wq_a.size()), 32'd1);
    if (wq_a.size() > 0) begin
      e = wq_a[0];
      check("cs_edge_addr", 32'(e[37:32]), 32'h07);
      check("cs_edge_data", e[31:0], word);
    end

    // Asynchronous reset during word 2 of a read burst
    send_hdr(1'b0, 6'h30);
    for (int i = 0; i < 40; i++) spi_bit(1'b0, m);
    rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(addr_a), 32'd0);
    check("mid_rst_wdata", wdata_a, 32'd0);
    check("mid_rst_wr", 32'(wr_a), 32'd0);
    check("mid_rst_rd", 32'(rds_a), 32'd0);
    check("mid_rst_miso", 32'(miso_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    cs_n = 1'b1;
    sck = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    w = '0; w[0] = $urandom;
    apply_vec(mk(1'b1, 6'h01, 1, w), "post_rst_wr");
    apply_vec(mk(1'b0, 6'h01, 1, w), "post_rst_rd");

    // 8-bit data build: three-word burst at 0x10
    clear_mon();
    tx_w = '0;
    tx_w[0] = 32'h01; tx_w[1] = 32'h02; tx_w[2] = 32'h03;
    run_frame(1'b1, 6'h10, 3, 8);
    check("dw8_wr_count", 32'(wq_b.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wq_b.size()) begin
        e8 = wq_b[i];
        check($sformatf("dw8_addr%0d", i), 32'(e8[13:8]), 32'h10 + 32'(i));
        check($sformatf("dw8_data%0d", i), 32'(e8[7:0]), 32'(i + 1));
      end
    end
    check("dw8_wide_no_wr", 32'(wq_a.size()), 32'd0);

    check("wr_pulse_width", 32'(dbl), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
